// File: rtl/canon_pkg.sv
// Shared types and helpers for the canon voice scheduler: sweep states and
// beat/address arithmetic used by the beat timer and the sweep engine.
package canon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } sweep_state_t;

    function automatic int voice_w(input int num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

    function automatic int entry_beat(input int v, input int offset);
        return v * offset;
    endfunction

    // Melody position of voice v, wrapped to the ROM size.
    function automatic int note_addr(input int beat, input int v, input int offset, input int aw);
        int mask_v;
        mask_v = (32'sd1 <<< aw) - 32'sd1;
        return (beat - entry_beat(v, offset)) & mask_v;
    endfunction

endpackage

// File: rtl/canon_beat_timer.sv
// Beat timer: counts frame ticks into beats and latches voice entries as the
// beat index reaches each voice's staggered entry point.
module canon_beat_timer
    import canon_pkg::*;
#(
    parameter int NUM_VOICES      = 4,
    parameter int NOTE_AW         = 6,
    parameter int FRAMES_PER_BEAT = 12,
    parameter int CANON_OFFSET    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  frame_tick,
    output logic [NOTE_AW-1:0]    beat,
    output logic [NUM_VOICES-1:0] voice_en
);

    localparam int FW = (FRAMES_PER_BEAT > 1) ? $clog2(FRAMES_PER_BEAT) : 1;

    logic [FW-1:0]         frame_cnt_r;
    logic [NOTE_AW-1:0]    beat_r;
    logic [NUM_VOICES-1:0] voice_en_r;
    logic [NUM_VOICES-1:0] hit_s;

    assign beat     = beat_r;
    assign voice_en = voice_en_r;

    // Which voices have their entry beat equal to the current beat.
    always_comb begin
        hit_s = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (int'(beat_r) == entry_beat(v, CANON_OFFSET)) begin
                hit_s[v] = 1'b1;
            end else begin
                hit_s[v] = 1'b0;
            end
        end
    end

    // Frame/beat counters and sticky voice entry; run low clears position.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            frame_cnt_r <= '0;
            beat_r      <= '0;
            voice_en_r  <= '0;
        end else begin
            voice_en_r <= voice_en_r | hit_s;
            if (frame_tick) begin
                if (frame_cnt_r == FW'(FRAMES_PER_BEAT - 1)) begin
                    frame_cnt_r <= '0;
                    beat_r      <= beat_r + NOTE_AW'(1'b1);
                end else begin
                    frame_cnt_r <= frame_cnt_r + FW'(1'b1);
                end
            end
        end
    end

endmodule

// File: rtl/canon_voice_sched.sv
// Canon voice scheduler: per sample tick, sweeps all voices through one shared
// note ROM port and phase adder. Optional CANON_MIX_EN adds an 8-bit mix_out.
module canon_voice_sched
    import canon_pkg::*;
#(
    parameter int NUM_VOICES      = 4,
    parameter int NOTE_AW         = 6,
    parameter int FRAMES_PER_BEAT = 12,
    parameter int CANON_OFFSET    = 8,
    parameter int PHASE_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  frame_tick,
    input  logic                  sample_tick,
    output logic                  rom_req,
    output logic [NOTE_AW-1:0]    rom_addr,
    input  logic                  rom_ack,
    input  logic [PHASE_W-1:0]    rom_inc,
    output logic [NUM_VOICES-1:0] sq_out,
    output logic                  sample_valid,
    output logic [NOTE_AW-1:0]    beat,
    output logic [NUM_VOICES-1:0] voice_en,
    output logic                  overrun
`ifdef CANON_MIX_EN
    ,
    output logic [7:0]            mix_out
`endif
);

    localparam int VW = voice_w(NUM_VOICES);
    localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

    sweep_state_t          state_r;
    logic [VW-1:0]         v_r;
    logic [NOTE_AW-1:0]    beat_q_r;
    logic [PHASE_W-1:0]    phase_r [NUM_VOICES];
    logic [NUM_VOICES-1:0] rest_r;
    logic                  rom_req_r;
    logic [NOTE_AW-1:0]    rom_addr_r;
    logic [NUM_VOICES-1:0] sq_out_r;
    logic                  sample_valid_r;
    logic                  overrun_r;
    logic [NUM_VOICES-1:0] sq_next_s;
    logic [VW-1:0]         tgt_v_s;
    logic [NOTE_AW-1:0]    tgt_beat_s;
    logic                  tgt_en_s;
    logic [NOTE_AW-1:0]    tgt_addr_s;

    canon_beat_timer #(
        .NUM_VOICES     (NUM_VOICES),
        .NOTE_AW        (NOTE_AW),
        .FRAMES_PER_BEAT(FRAMES_PER_BEAT),
        .CANON_OFFSET   (CANON_OFFSET)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .frame_tick(frame_tick),
        .beat      (beat),
        .voice_en  (voice_en)
    );

    assign rom_req      = rom_req_r;
    assign rom_addr     = rom_addr_r;
    assign sq_out       = sq_out_r;
    assign sample_valid = sample_valid_r;
    assign overrun      = overrun_r;

    // Voice considered on the next request decision; IDLE starts at voice 0
    // using the live beat, later voices use the beat latched at sweep start.
    always_comb begin
        if (state_r == ST_IDLE) begin
            tgt_v_s    = '0;
            tgt_beat_s = beat;
        end else begin
            tgt_v_s    = v_r + VW'(1'b1);
            tgt_beat_s = beat_q_r;
        end
        tgt_en_s   = voice_en[tgt_v_s] & run;
        tgt_addr_s = NOTE_AW'(note_addr(int'(tgt_beat_s), int'(tgt_v_s), CANON_OFFSET, NOTE_AW));
    end

    // Square bit per voice from the phase MSB, silenced when resting or off.
    always_comb begin
        sq_next_s = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sq_next_s[v] = phase_r[v][PHASE_W-1] & voice_en[v] & ~rest_r[v] & run;
        end
    end

`ifdef CANON_MIX_EN
    logic [7:0] mix_r;
    logic [7:0] mix_next_s;
    assign mix_out = mix_r;

    // Saturating mix level proportional to the number of high voices.
    always_comb begin
        int cnt_v;
        int lvl_v;
        cnt_v = 0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            cnt_v = cnt_v + int'(sq_next_s[v]);
        end
        lvl_v = cnt_v * (256 / NUM_VOICES);
        if (lvl_v > 255) begin
            mix_next_s = 8'd255;
        end else begin
            mix_next_s = 8'(lvl_v);
        end
    end
`endif

    // Sweep engine. The request decision and the result registration are
    // taken on the edges leaving IDLE/NEXT, so a voice costs one NEXT cycle
    // plus its ROM wait, and the final NEXT cycle publishes sq_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            v_r            <= '0;
            beat_q_r       <= '0;
            rest_r         <= '0;
            rom_req_r      <= 1'b0;
            rom_addr_r     <= '0;
            sq_out_r       <= '0;
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_r[v] <= '0;
            end
`ifdef CANON_MIX_EN
            mix_r          <= 8'd0;
`endif
        end else begin
            sample_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sample_tick && run) begin
                        beat_q_r <= beat;
                        v_r      <= '0;
                        if (tgt_en_s) begin
                            rom_req_r  <= 1'b1;
                            rom_addr_r <= tgt_addr_s;
                            state_r    <= ST_WAIT;
                        end else begin
                            state_r    <= ST_NEXT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rom_ack) begin
                        rom_req_r <= 1'b0;
                        if (run) begin
                            if (rom_inc == '0) begin
                                rest_r[v_r] <= 1'b1;
                            end else begin
                                rest_r[v_r]  <= 1'b0;
                                phase_r[v_r] <= phase_r[v_r] + rom_inc;
                            end
                        end
                        state_r <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (v_r == LAST_V) begin
                        sq_out_r       <= sq_next_s;
                        sample_valid_r <= 1'b1;
`ifdef CANON_MIX_EN
                        mix_r          <= mix_next_s;
`endif
                        state_r        <= ST_IDLE;
                    end else begin
                        v_r <= tgt_v_s;
                        if (tgt_en_s) begin
                            rom_req_r  <= 1'b1;
                            rom_addr_r <= tgt_addr_s;
                            state_r    <= ST_WAIT;
                        end else begin
                            state_r    <= ST_NEXT;
                        end
                    end
                end
                default: begin
                    rom_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase

            if (!run) begin
                overrun_r <= 1'b0;
                rest_r    <= '0;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    phase_r[v] <= '0;
                end
            end else if (sample_tick && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_canon_voice_sched.sv
// Directed scoreboard bench for canon_voice_sched: expected ROM addresses and
// sweep results are queued at stimulus time and checked as the DUT emits them.
module tb_canon_voice_sched;

    logic        clk;
    logic        rst;
    logic        run;
    logic        frame_tick;
    logic        sample_tick;
    logic        rom_req;
    logic [5:0]  rom_addr;
    logic        rom_ack;
    logic [15:0] rom_inc;
    logic [3:0]  sq_out;
    logic        sample_valid;
    logic [5:0]  beat;
    logic [3:0]  voice_en;
    logic        overrun;

    typedef struct {
        logic [3:0] sq;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [5:0] addr_q[$];

    int n_compared = 0;
    int n_mismatch = 0;
    int cyc        = 0;
    int tick_cyc   = 0;
    int req_age    = 0;
    int ack_delay  = 0;
    logic       req_prev  = 1'b0;
    logic [5:0] held_addr = 6'd0;

    canon_voice_sched dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .frame_tick  (frame_tick),
        .sample_tick (sample_tick),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_inc     (rom_inc),
        .sq_out      (sq_out),
        .sample_valid(sample_valid),
        .beat        (beat),
        .voice_en    (voice_en),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: acknowledges once the request has been held ack_delay cycles.
    assign rom_ack = rom_req && (req_age >= ack_delay);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        assert (got === exp) else begin
            n_mismatch++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor on the falling edge: request addresses, hold stability, results.
    always @(negedge clk) begin
        if (rom_req) begin
            if (!req_prev) begin
                check("rom_req_expected", {31'd0, (addr_q.size() > 0)}, 32'd1);
                if (addr_q.size() > 0) begin
                    check("rom_addr", {26'd0, rom_addr}, {26'd0, addr_q.pop_front()});
                end
            end else begin
                check("rom_addr_stable", {26'd0, rom_addr}, {26'd0, held_addr});
            end
            held_addr = rom_addr;
        end
        req_prev = rom_req;
        req_age  = rom_req ? req_age + 1 : 0;
        if (sample_valid) begin
            check("sample_valid_expected", {31'd0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sq_out", {28'd0, sq_out}, {28'd0, e.sq});
                check("latency", cyc - tick_cyc, e.lat);
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0) && (n < 200)) begin
            step(1);
            n++;
        end
        check("drain_timeout", sb_q.size(), 32'd0);
    endtask

    task automatic run_sweep(input logic [3:0] sq, input int lat);
        sb_q.push_back('{sq: sq, lat: lat});
        sample_tick = 1'b1;
        tick_cyc    = cyc;
        step(1);
        sample_tick = 1'b0;
        wait_drain();
    endtask

    logic [15:0] incs  [8] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000,
                               16'h8000, 16'h0000, 16'h0000, 16'h4000};
    logic [3:0]  expsq [8] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1};

    initial begin
        rst = 1'b1; run = 1'b0; frame_tick = 1'b0; sample_tick = 1'b0; rom_inc = 16'h0000;
        step(3);
        check("rst_rom_req", {31'd0, rom_req}, 32'd0);
        check("rst_rom_addr", {26'd0, rom_addr}, 32'd0);
        check("rst_sq_out", {28'd0, sq_out}, 32'd0);
        check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_beat", {26'd0, beat}, 32'd0);
        check("rst_voice_en", {28'd0, voice_en}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        step(1);
        run = 1'b1;
        step(1);
        check("v0_entry", {28'd0, voice_en}, 32'h1);

        // Voice 0 alone at beat 0: phase walk, rests and held phase.
        for (int i = 0; i < 8; i++) begin
            rom_inc = incs[i];
            addr_q.push_back(6'd0);
            run_sweep(expsq[i], 6);
        end

        // Slow ROM with an overlapping sample_tick (phase C000 -> 0000).
        ack_delay = 5;
        rom_inc   = 16'h4000;
        addr_q.push_back(6'd0);
        sb_q.push_back('{sq: 4'h0, lat: 10});
        sample_tick = 1'b1;
        tick_cyc    = cyc;
        step(1);
        sample_tick = 1'b0;
        step(2);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        wait_drain();
        step(12);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("no_extra_sweep", sb_q.size(), 32'd0);
        ack_delay = 0;

        // Beat timer and staggered voice entry.
        frame_tick = 1'b1;
        step(96);
        frame_tick = 1'b0;
        step(1);
        check("beat_8", {26'd0, beat}, 32'd8);
        check("voice_en_beat8", {28'd0, voice_en}, 32'h3);
        frame_tick = 1'b1;
        step(192);
        frame_tick = 1'b0;
        step(1);
        check("beat_24", {26'd0, beat}, 32'd24);
        check("voice_en_beat24", {28'd0, voice_en}, 32'hF);
        frame_tick = 1'b1;
        step(600);
        frame_tick = 1'b0;
        step(1);
        check("beat_wrap_10", {26'd0, beat}, 32'd10);
        check("voice_en_after_wrap", {28'd0, voice_en}, 32'hF);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Full sweep at beat 10.
        rom_inc = 16'h8000;
        addr_q.push_back(6'd10); addr_q.push_back(6'd2);
        addr_q.push_back(6'd58); addr_q.push_back(6'd50);
        run_sweep(4'hF, 9);

        // frame_tick wrapping the beat in the same cycle as sample_tick.
        frame_tick = 1'b1;
        step(11);
        addr_q.push_back(6'd10); addr_q.push_back(6'd2);
        addr_q.push_back(6'd58); addr_q.push_back(6'd50);
        sb_q.push_back('{sq: 4'h0, lat: 9});
        sample_tick = 1'b1;
        tick_cyc    = cyc;
        step(1);
        sample_tick = 1'b0;
        frame_tick  = 1'b0;
        wait_drain();
        check("beat_after_overlap", {26'd0, beat}, 32'd11);

        // run drops while voice 0 waits on the ROM.
        ack_delay = 5;
        rom_inc   = 16'h4000;
        addr_q.push_back(6'd11);
        sb_q.push_back('{sq: 4'h0, lat: 10});
        sample_tick = 1'b1;
        tick_cyc    = cyc;
        step(1);
        sample_tick = 1'b0;
        run         = 1'b0;
        wait_drain();
        check("rundrop_beat", {26'd0, beat}, 32'd0);
        check("rundrop_voice_en", {28'd0, voice_en}, 32'd0);
        check("rundrop_sq_out", {28'd0, sq_out}, 32'd0);
        check("rundrop_overrun", {31'd0, overrun}, 32'd0);

        // rst asserted mid-handshake.
        run = 1'b1;
        step(1);
        addr_q.push_back(6'd0);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(2);
        check("pre_rst_rom_req", {31'd0, rom_req}, 32'd1);
        rst = 1'b1;
        step(1);
        check("rst_mid_rom_req", {31'd0, rom_req}, 32'd0);
        check("rst_mid_rom_addr", {26'd0, rom_addr}, 32'd0);
        check("rst_mid_sq_out", {28'd0, sq_out}, 32'd0);
        check("rst_mid_beat", {26'd0, beat}, 32'd0);
        check("rst_mid_voice_en", {28'd0, voice_en}, 32'd0);
        check("rst_mid_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        step(12);
        check("sb_left", sb_q.size(), 32'd0);
        check("addr_left", addr_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/canon_voice_sched.md
Name: canon_voice_sched

Overview:
- Sequences the canon's polyphonic audio. Derives beats from the video frame tick, which is the vsync-rate pulse from the VGA timing block.
- Staggers voice entries by a fixed beat offset, which produces the canon.
- On every audio sample tick, shares one note ROM port and one phase adder round-robin across all voices.
- Produces per-voice square bits that feed the PWM audio stage, which drives uio_out[7].

Parameters:
- NUM_VOICES, 4, number of canon voices; must be a power of two, ≥2.
- NOTE_AW, 6, melody ROM address width. Melody length is 2^NOTE_AW beats.
- FRAMES_PER_BEAT, 12, number of frame_tick pulses per beat.
- CANON_OFFSET, 8, beats between successive voice entries. Constraint: NUM_VOICES*CANON_OFFSET < 2^NOTE_AW.
- PHASE_W, 16, phase accumulator and increment width.

Ports:
- clk, in, 1, system clock (single clock domain).
- rst, in, 1, synchronous, active-high reset.
- run, in, 1, enables the sequencer. Low clears musical position.
- frame_tick, in, 1, one-cycle pulse per video frame.
- sample_tick, in, 1, one-cycle pulse per audio sample.
- rom_req, out, 1, note ROM request; registered.
- rom_addr, out, NOTE_AW, note ROM address; registered, stable while rom_req=1.
- rom_ack, in, 1, ROM response valid; rom_inc is sampled in the same cycle.
- rom_inc, in, PHASE_W, phase increment for the note; 0 means rest.
- sq_out, out, NUM_VOICES, per-voice square-wave bit; bit v = voice v.
- sample_valid, out, 1, one-cycle pulse when sq_out has been updated.
- beat, out, NOTE_AW, current beat index.
- voice_en, out, NUM_VOICES, voices that have entered.
- overrun, out, 1, sticky flag: a sample_tick was dropped.

Behaviour:
- Reset values: every output is 0, all phases are 0, frame counter is 0, FSM is in IDLE.
- Beat timer:
  - Counts frame_tick pulses only while run=1.
  - At count FRAMES_PER_BEAT-1 a frame_tick wraps the count to 0 and increments beat modulo 2^NOTE_AW.
- Voice entry:
  - voice_en[0] sets on the first cycle with run=1.
  - voice_en[v] sets when beat == v*CANON_OFFSET.
  - Once set, a bit stays set across beat wrap.
- run=0:
  - Next cycle, beat, frame count, voice_en, phases and overrun are cleared.
  - An in-flight sweep completes its ROM handshake but does not update phases; sample_valid still pulses with sq_out=0.
  - No new sweep starts while run=0.
- Sweep FSM: IDLE → REQ → WAIT → NEXT → … → DONE → IDLE.
  - IDLE: sample_tick with run=1 latches beat into beat_q, sets v=0 and goes to REQ.
  - REQ: if voice_en[v], drive rom_req=1 and rom_addr=(beat_q - v*CANON_OFFSET) mod 2^NOTE_AW, then go to WAIT. Otherwise go directly to NEXT; that voice's phase is held and its sq bit is 0.
  - WAIT: hold rom_req and rom_addr until rom_ack=1. In the ack cycle:
    - phase[v] += rom_inc, modulo 2^PHASE_W;
    - drop rom_req next cycle;
    - if rom_inc==0, hold phase and mark voice v as resting.
  - NEXT: v+1. When v==NUM_VOICES-1, go to DONE.
  - DONE: register sq_out[v] = phase[v][PHASE_W-1] & voice_en[v] & !rest[v]. Pulse sample_valid, then go to IDLE.
- Latency: with rom_ack tied high, sample_valid fires 2·(enabled voices) + 1·(disabled voices) + 1 cycles after the sample_tick cycle.
- sample_tick outside IDLE is dropped and overrun is set. overrun clears only on rst or run=0.
- frame_tick during a sweep updates beat normally. The sweep keeps using beat_q.
- frame_tick and sample_tick arriving in the same cycle: the beat update and the beat_q latch are both taken from the pre-update beat.
- rst asserted mid-handshake: rom_req drops next cycle. The ROM shares rst and tolerates an abandoned request.

Optional Feature:
- Macro: CANON_MIX_EN.
- Defined:
  - Adds output port mix_out, width 8.
  - mix_out = min(255, popcount(sq_out)·(256/NUM_VOICES)).
  - Registered and updated in the same DONE cycle as sq_out; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- canon_pkg contains:
  - FSM state enum (IDLE, REQ, WAIT, NEXT, DONE);
  - voice index width $clog2(NUM_VOICES);
  - function entry_beat(v) = v*CANON_OFFSET;
  - function note_addr(beat, v).
- One sub-module, canon_beat_timer: frame counter, beat counter and voice_en latching. The sweep FSM and phase registers stay in the top.

Test Plan:
- run=1, 96 frame_ticks, FRAMES_PER_BEAT=12 → beat=8, voice_en=4'b0011. After a further 192 frame_ticks → beat=24, voice_en=4'b1111.
- beat=0, voice_en=0001, rom_ack tied high, one sample_tick → exactly one rom_req with addr 0; sample_valid 6 cycles after the tick.
- beat=10, all voices enabled, rom_ack tied high → addresses in order 10, 2, 58, 50; sample_valid 9 cycles after the tick.
- Voice 0 only, rom_inc=16'h4000 on every ack, 4 sample_ticks → sq_out[0] sequence 0, 1, 1, 0. rom_inc=0 → sq_out[0]=0 and phase unchanged.
- rom_ack delayed 5 cycles → rom_req and rom_addr stable throughout the wait. A sample_tick during the wait → overrun=1, and sweep output is unchanged.
- run drops mid-WAIT → the handshake completes, then beat=0, voice_en=0, sq_out=0. Separately, rst mid-WAIT → rom_req=0 on the next cycle and all outputs are 0.
